// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the two-requester ALU arbiter: FSM states, ALU control codes.
package alu_arbiter_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned CTRL_W  = 3;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_EXEC = 2'd1;
    localparam logic [STATE_W-1:0] ST_RESP = 2'd2;

    localparam logic [CTRL_W-1:0] CTRL_ADD = 3'b000;
    localparam logic [CTRL_W-1:0] CTRL_SUB = 3'b001;
    localparam logic [CTRL_W-1:0] CTRL_AND = 3'b010;
    localparam logic [CTRL_W-1:0] CTRL_OR  = 3'b011;

    localparam int unsigned CTRL_ILLEGAL_BIT = 2;

    // The four defined operations are legal; any code with the illegal bit set is rejected.
    function automatic logic ctrl_is_illegal(input logic [CTRL_W-1:0] ctrl);
        case (ctrl)
            CTRL_ADD, CTRL_SUB, CTRL_AND, CTRL_OR: return 1'b0;
            default:                               return ctrl[CTRL_ILLEGAL_BIT];
        endcase
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_grant2.sv
// Two-way round-robin grant: a lone valid wins, a tie goes to the side not granted last.
module rr_grant2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_grant_i,
    output logic grant_c_o,
    output logic any_c_o
);

    // Grant id is 1 for requester 1, 0 for requester 0.
    always_comb begin
        any_c_o   = req0_i | req1_i;
        grant_c_o = 1'b0;
        if (req0_i && req1_i) begin
            grant_c_o = ~last_grant_i;
        end else if (req1_i) begin
            grant_c_o = 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters, one operation at a time.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNTW  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    input  logic [CTRL_W-1:0] req1_ctrl,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]  alu_result,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [WIDTH-1:0]  resp_result,
    output logic              resp_zero,
    output logic              resp_err,
    output logic [CNTW-1:0]   op_count
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
    logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
    logic               id_q, id_d, last_q, last_d;
    logic               valid_q, valid_d, zero_q, zero_d, err_q, err_d;
    logic [CNTW-1:0]    count_q, count_d;
    logic               grant_c, any_c;

    rr_grant2 u_rr_grant2 (
        .req0_i       (req0_valid),
        .req1_i       (req1_valid),
        .last_grant_i (last_q),
        .grant_c_o    (grant_c),
        .any_c_o      (any_c)
    );

    // Next-state, operand latching, result capture and handshake bookkeeping.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        ctrl_d     = ctrl_q;
        id_d       = id_q;
        last_d     = last_q;
        valid_d    = valid_q;
        result_d   = result_q;
        zero_d     = zero_q;
        err_d      = err_q;
        count_d    = count_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rst && any_c) begin
                    req0_ready = ~grant_c;
                    req1_ready = grant_c;
                end
                if (req0_ready && req0_valid) begin
                    a_d     = req0_a;
                    b_d     = req0_b;
                    ctrl_d  = req0_ctrl;
                    id_d    = 1'b0;
                    state_d = ST_EXEC;
                end else if (req1_ready && req1_valid) begin
                    a_d     = req1_a;
                    b_d     = req1_b;
                    ctrl_d  = req1_ctrl;
                    id_d    = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (ctrl_is_illegal(ctrl_q)) begin
                    result_d = '0;
                    zero_d   = 1'b1;
                    err_d    = 1'b1;
                end else begin
                    result_d = alu_result;
                    zero_d   = (alu_result == '0);
                    err_d    = 1'b0;
                end
                valid_d = 1'b1;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    valid_d = 1'b0;
                    last_d  = id_q;
                    count_d = count_q + CNTW'(1);
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operation, response and counter registers; last grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            ctrl_q   <= '0;
            id_q     <= 1'b0;
            last_q   <= 1'b1;
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            ctrl_q   <= ctrl_d;
            id_q     <= id_d;
            last_q   <= last_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
            count_q  <= count_d;
        end
    end

    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_ctrl    = ctrl_q;
    assign resp_valid  = valid_q;
    assign resp_id     = id_q;
    assign resp_result = result_q;
    assign resp_zero   = zero_q;
    assign resp_err    = err_q;
    assign op_count    = count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table plus contention, backpressure, reset and counter-wrap sequences.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic        clk, rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_ctrl, req1_ctrl, alu_ctrl;
    logic [31:0] alu_a, alu_b, alu_result, resp_result;
    logic        resp_valid, resp_ready, resp_id, resp_zero, resp_err;
    logic [15:0] op_count;

    // Small instance for counter wrap
    logic        s_r0v, s_r0rdy, s_r1v, s_r1rdy, s_rv, s_rr, s_id, s_zero, s_err;
    logic [7:0]  s_r0a, s_r0b, s_r1a, s_r1b, s_alu_a, s_alu_b, s_alu_res, s_res;
    logic [2:0]  s_r0c, s_r1c, s_alu_c;
    logic [1:0]  s_cnt;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_count;

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ctrl;
        logic [31:0] er;
        logic        ez;
        logic        ee;
    } vec_t;
    vec_t vecs[8];

    alu_arbiter #(.WIDTH(32), .CNTW(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_zero(resp_zero), .resp_err(resp_err), .op_count(op_count)
    );

    alu_arbiter #(.WIDTH(8), .CNTW(2)) dut_small (
        .clk(clk), .rst(rst),
        .req0_valid(s_r0v), .req0_ready(s_r0rdy), .req0_a(s_r0a), .req0_b(s_r0b), .req0_ctrl(s_r0c),
        .req1_valid(s_r1v), .req1_ready(s_r1rdy), .req1_a(s_r1a), .req1_b(s_r1b), .req1_ctrl(s_r1c),
        .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_ctrl(s_alu_c), .alu_result(s_alu_res),
        .resp_valid(s_rv), .resp_ready(s_rr), .resp_id(s_id),
        .resp_result(s_res), .resp_zero(s_zero), .resp_err(s_err), .op_count(s_cnt)
    );

    // External ALU model; illegal codes return garbage that the arbiter must mask.
    always_comb begin
        case (alu_ctrl)
            CTRL_ADD: alu_result = alu_a + alu_b;
            CTRL_SUB: alu_result = alu_a - alu_b;
            CTRL_AND: alu_result = alu_a & alu_b;
            CTRL_OR:  alu_result = alu_a | alu_b;
            default:  alu_result = 32'hDEAD_BEEF;
        endcase
    end

    assign s_alu_res = s_alu_a + s_alu_b;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Single request from requester id, starting at a negedge with the DUT idle.
    task automatic run_op(input logic id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] ctrl,
                          input logic [31:0] er, input logic ez, input logic ee);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_ctrl = ctrl;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_ctrl = ctrl;
        end
        #1;
        chk("own_ready", id ? req1_ready : req0_ready, 32'd1);
        chk("other_ready", id ? req0_ready : req1_ready, 32'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("exec_resp_valid", resp_valid, 32'd0);
        chk("exec_alu_a", alu_a, a);
        chk("exec_alu_ctrl", alu_ctrl, 32'(ctrl));
        @(negedge clk);
        chk("resp_valid", resp_valid, 32'd1);
        chk("resp_id", resp_id, 32'(id));
        chk("resp_result", resp_result, er);
        chk("resp_zero", resp_zero, 32'(ez));
        chk("resp_err", resp_err, 32'(ee));
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        exp_count = exp_count + 16'd1;
        chk("after_hs_valid", resp_valid, 32'd0);
        chk("op_count", op_count, 32'(exp_count));
    endtask

    initial begin
        int got;
        int cyc;
        int last_cyc;
        int exp_seq[5];

        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req0_ctrl = '0;
        req1_a = '0; req1_b = '0; req1_ctrl = '0;
        s_r0v = 1'b0; s_r1v = 1'b0; s_rr = 1'b0;
        s_r0a = 8'd1; s_r0b = 8'd1; s_r0c = CTRL_ADD;
        s_r1a = '0; s_r1b = '0; s_r1c = '0;
        exp_count = '0;

        vecs[0] = '{1'b0, 32'd5,          32'd3,          3'b000, 32'd8,          1'b0, 1'b0};
        vecs[1] = '{1'b1, 32'd7,          32'd7,          3'b001, 32'd0,          1'b1, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_F0F0,  32'h0000_0FF0,  3'b010, 32'h0000_00F0,  1'b0, 1'b0};
        vecs[3] = '{1'b1, 32'h0000_00F0,  32'h0000_000F,  3'b011, 32'h0000_00FF,  1'b0, 1'b0};
        vecs[4] = '{1'b1, 32'd9,          32'd4,          3'b101, 32'd0,          1'b1, 1'b1};
        vecs[5] = '{1'b0, 32'd0,          32'd1,          3'b001, 32'hFFFF_FFFF,  1'b0, 1'b0};
        vecs[6] = '{1'b1, 32'hFFFF_FFFF,  32'd1,          3'b000, 32'd0,          1'b1, 1'b0};
        vecs[7] = '{1'b0, 32'd3,          32'd3,          3'b111, 32'd0,          1'b1, 1'b1};
        exp_seq[0] = 1; exp_seq[1] = 2; exp_seq[2] = 3; exp_seq[3] = 0; exp_seq[4] = 1;

        // Reset state
        @(negedge clk);
        req0_valid = 1'b1;
        #1;
        chk("rst_ready0", req0_ready, 32'd0);
        chk("rst_resp_valid", resp_valid, 32'd0);
        chk("rst_err", resp_err, 32'd0);
        chk("rst_zero", resp_zero, 32'd0);
        chk("rst_result", resp_result, 32'd0);
        chk("rst_id", resp_id, 32'd0);
        chk("rst_count", op_count, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        req0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Vector table
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].ctrl, vecs[i].er, vecs[i].ez, vecs[i].ee);
        end

        // Backpressure: response held, other valids ignored
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd20; req0_ctrl = CTRL_ADD;
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_ctrl = CTRL_ADD;
        @(negedge clk);
        req0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", resp_valid, 32'd1);
            chk("bp_result", resp_result, 32'd30);
            chk("bp_id", resp_id, 32'd0);
            chk("bp_no_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
            chk("bp_count", op_count, 32'(exp_count));
            @(negedge clk);
        end
        resp_ready = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        resp_ready = 1'b0;
        exp_count = exp_count + 16'd1;
        chk("bp_hs_valid", resp_valid, 32'd0);
        chk("bp_count_inc", op_count, 32'(exp_count));

        // Asynchronous reset in EXEC aborts the operation
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_ctrl = CTRL_ADD;
        @(negedge clk);
        req0_valid = 1'b0;
        chk("pre_rst_alu_a", alu_a, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_alu_a", alu_a, 32'd0);
        chk("arst_count", op_count, 32'd0);
        chk("arst_valid", resp_valid, 32'd0);
        exp_count = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_no_resp", resp_valid, 32'd0);
        @(negedge clk);
        chk("abort_no_resp2", resp_valid, 32'd0);
        chk("abort_count", op_count, 32'd0);

        // Contention: tie after reset goes to req0, then alternation
        req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd7; req0_ctrl = CTRL_SUB;
        req1_valid = 1'b1; req1_a = 32'h0000_00F0; req1_b = 32'h0000_000F; req1_ctrl = CTRL_OR;
        resp_ready = 1'b1;
        #1;
        chk("tie_ready0", req0_ready, 32'd1);
        chk("tie_ready1", req1_ready, 32'd0);
        got = 0; cyc = 0; last_cyc = -1;
        while (got < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (resp_valid) begin
                chk("cont_id", resp_id, 32'(got % 2));
                chk("cont_result", resp_result, (got % 2 == 0) ? 32'd0 : 32'h0000_00FF);
                chk("cont_zero", resp_zero, (got % 2 == 0) ? 32'd1 : 32'd0);
                if (last_cyc >= 0) chk("cont_interval", 32'(cyc - last_cyc), 32'd3);
                last_cyc = cyc;
                got++;
            end
        end
        chk("cont_responses", 32'(got), 32'd4);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        resp_ready = 1'b0;
        exp_count = exp_count + 16'(got);
        chk("cont_count", op_count, 32'(exp_count));

        // Counter wrap on the CNTW=2 instance
        for (int i = 0; i < 5; i++) begin
            s_r0v = 1'b1;
            @(negedge clk);
            s_r0v = 1'b0;
            @(negedge clk);
            chk("wrap_valid", s_rv, 32'd1);
            chk("wrap_result", s_res, 32'd2);
            s_rr = 1'b1;
            @(negedge clk);
            s_rr = 1'b0;
            chk("wrap_count", s_cnt, 32'(exp_seq[i]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand and result width.
REQ-002 Parameter CNTW, default 16, SHALL set the completed-operation counter width.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 req0_valid/req1_valid  input  1 each  SHALL flag a pending operation from requester 0/1.
REQ-006 req0_ready/req1_ready  output  1 each  SHALL accept the requester's operation when high with its valid.
REQ-007 reqN_a, reqN_b  input  WIDTH each  SHALL carry requester N's operands.
REQ-008 reqN_ctrl  input  3  SHALL carry requester N's ALU control code.
REQ-009 alu_a, alu_b  output  WIDTH; alu_ctrl  output  3  SHALL drive the shared combinational ALU.
REQ-010 alu_result  input  WIDTH  SHALL return the ALU output in the same cycle.
REQ-011 resp_valid  output  1; resp_ready  input  1  SHALL form the single response handshake.
REQ-012 resp_id  output  1  SHALL identify the requester owning the response.
REQ-013 resp_result  output  WIDTH; resp_zero  output  1; resp_err  output  1  SHALL carry the result, a zero flag and an illegal-code flag.
REQ-014 op_count  output  CNTW  SHALL count completed responses.

Function
REQ-015 The FSM SHALL have three states: IDLE, EXEC, RESP.
REQ-016 In IDLE, reqN_ready SHALL be high only for the granted requester, combinationally, and only when at least one valid is high.
REQ-017 Arbitration SHALL be round-robin: a single valid wins; with both valid, the requester not granted last wins.
REQ-018 On an accepted handshake, the arbiter SHALL latch a, b, ctrl and the id, then move IDLE->EXEC.
REQ-019 In EXEC, alu_a/alu_b/alu_ctrl SHALL be driven from the latched registers; at the cycle end the result SHALL be captured and the state SHALL move EXEC->RESP.
REQ-020 Outside EXEC, alu_a/alu_b/alu_ctrl SHALL hold the latched values (no toggling from requester inputs).
REQ-021 In RESP, resp_valid SHALL be high, with resp_result/resp_id/resp_zero/resp_err stable until resp_ready is sampled high.
REQ-022 A RESP handshake SHALL move RESP->IDLE, update last-grant to resp_id and increment op_count.
REQ-023 A new request SHALL NOT be accepted in the handshake cycle; the minimum issue interval SHALL be 3 cycles, and the accept-to-resp_valid latency SHALL be 2 cycles.
REQ-024 A ctrl with bit2=1 SHALL be illegal: resp_err=1, resp_result=0, resp_zero=1; it SHALL still consume EXEC/RESP and count.
REQ-025 A legal ctrl SHALL give resp_err=0, resp_result=alu_result, and resp_zero=(alu_result==0).
REQ-026 op_count SHALL wrap from 2^CNTW-1 to 0 without any flag.
REQ-027 A valid deasserted before acceptance SHALL be dropped silently; valids changing during EXEC/RESP SHALL be ignored.

Reset
REQ-028 rst SHALL force IDLE, all ready/resp_valid/resp_err low, resp_zero low, resp_result/resp_id/op_count/latched registers 0, and last-grant=1 (requester 0 wins the first tie).
REQ-029 Reset mid-EXEC or mid-RESP SHALL abort the operation with no response and no count.

Structure
REQ-030 A shared package SHALL hold the state enum, the ctrl encodings (ADD=000, SUB=001, AND=010, OR=011) and the illegal-bit index.
REQ-031 The round-robin grant logic SHALL be a natural sub-module, rr_grant2; the ALU itself SHALL stay external.

Verification
REQ-032 Single request: req0 a=5, b=3, ctrl=000 -> resp_valid 2 cycles after accept, result=8, id=0, zero=0.
REQ-033 Contention: both valid continuously (req0 SUB 7-7, req1 OR 0xF0|0x0F) -> grants in order 0,1,0,1; results 0 with zero=1, then 0xFF.
REQ-034 Backpressure: resp_ready low for 5 cycles -> outputs stable, no new ready; then one handshake and count+1.
REQ-035 Illegal ctrl=101 from req1 -> resp_err=1, result=0, zero=1, id=1, op_count increments.
REQ-036 Reset asserted asynchronously in EXEC -> IDLE immediately, no resp_valid, op_count=0; the next tie goes to req0.
REQ-037 CNTW=2 with 5 completed ops -> op_count sequence 1,2,3,0,1.
